// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog reset sequencer: state encoding and
// default timing constants that the watchdog and sequencer agree on.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_LOCKED  = 2'd3
  } wdt_state_e;

  // Default timing; the watchdog's own reload period lives alongside so both
  // blocks are tuned from one place.
  localparam int DEFAULT_HOLD_CYCLES   = 16;
  localparam int DEFAULT_STAGE_GAP     = 4;
  localparam int DEFAULT_NUM_STAGES    = 3;
  localparam int DEFAULT_MAX_RETRIES   = 3;
  localparam int DEFAULT_STABLE_CYCLES = 64;
  localparam int DEFAULT_WDT_PERIOD    = 1024;

  // Largest of three integers, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..v, never less than one.
  function automatic int count_width(input int v);
    return (v > 0) ? $clog2(v + 1) : 1;
  endfunction

endpackage

// File: rtl/wdt_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment: the
// watchdog expiry and software clear come in, staged resets, the watchdog
// kick and status go out.
interface wdt_reset_sequencer_if
  import wdt_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int RETRY_W    = count_width(DEFAULT_MAX_RETRIES)
);

  logic                  wdt_timeout;
  logic                  clear_fault;
  logic [NUM_STAGES-1:0] sys_rst;
  logic                  wdt_kick;
  logic                  fault_lock;
  logic [RETRY_W-1:0]    retry_count;
  logic                  busy;

  // The sequencer side: consumes the watchdog expiry, produces resets.
  modport master (
    input  wdt_timeout,
    input  clear_fault,
    output sys_rst,
    output wdt_kick,
    output fault_lock,
    output retry_count,
    output busy
  );

  // The environment side: watchdog and software control.
  modport slave (
    output wdt_timeout,
    output clear_fault,
    input  sys_rst,
    input  wdt_kick,
    input  fault_lock,
    input  retry_count,
    input  busy
  );

endinterface

// File: rtl/wdt_reset_sequencer.sv
// Turns a watchdog expiry into a held system reset that is released one
// stage at a time, kicks the watchdog while recovering, and escalates to a
// latched fault lock after too many back-to-back recoveries.
module wdt_reset_sequencer
  import wdt_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int STAGE_GAP     = DEFAULT_STAGE_GAP,
  parameter int NUM_STAGES    = DEFAULT_NUM_STAGES,
  parameter int MAX_RETRIES   = DEFAULT_MAX_RETRIES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  wdt_reset_sequencer_if.master  seq
);

  localparam int TIMER_W = count_width(max3(HOLD_CYCLES, STAGE_GAP, STABLE_CYCLES));
  localparam int RETRY_W = count_width(MAX_RETRIES);

  localparam logic [TIMER_W-1:0]    HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    GAP_LAST    = TIMER_W'(STAGE_GAP - 1);
  localparam logic [TIMER_W-1:0]    STABLE_END  = TIMER_W'(STABLE_CYCLES);
  localparam logic [TIMER_W-1:0]    TIMER_ONE   = TIMER_W'(1);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0]    RETRY_ONE   = RETRY_W'(1);
  localparam logic [NUM_STAGES-1:0] ALL_ON      = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] FIRST_DROP  = ALL_ON << 1;

  wdt_state_e            state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  kick_q;
  logic                  lock_q;
  logic                  busy_q;

  logic [RETRY_W-1:0]    retry_base;
  logic                  can_retry;
  logic [NUM_STAGES-1:0] mask_shifted;

  // Software clear takes effect before any increment, so a clear and a
  // timeout in the same cycle leave the count at one.
  always_comb begin
    retry_base   = seq.clear_fault ? '0 : retry_q;
    can_retry    = (retry_base < RETRY_LIMIT);
    mask_shifted = mask_q << 1;
  end

  // Next-state logic: one shared timer is reloaded on every state change.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    retry_d = retry_q;

    case (state_q)
      ST_ASSERT: begin
        mask_d = ALL_ON;
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          mask_d  = FIRST_DROP;
          state_d = (FIRST_DROP == '0) ? ST_IDLE : ST_RELEASE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      ST_RELEASE: begin
        retry_d = retry_base;
        if (seq.wdt_timeout) begin
          timer_d = '0;
          mask_d  = ALL_ON;
          if (can_retry) begin
            retry_d = retry_base + RETRY_ONE;
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          mask_d  = mask_shifted;
          if (mask_shifted == '0) begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      ST_IDLE: begin
        mask_d  = '0;
        retry_d = retry_base;
        if (seq.wdt_timeout) begin
          timer_d = '0;
          mask_d  = ALL_ON;
          if (can_retry) begin
            retry_d = retry_base + RETRY_ONE;
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (timer_q != STABLE_END) begin
          timer_d = timer_q + TIMER_ONE;
          if (timer_d == STABLE_END) begin
            retry_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        mask_d  = ALL_ON;
        timer_d = '0;
        if (seq.clear_fault) begin
          retry_d = '0;
          state_d = ST_ASSERT;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        timer_d = '0;
        mask_d  = ALL_ON;
        retry_d = '0;
      end
    endcase
  end

  // State, timer, stage mask and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      timer_q <= '0;
      mask_q  <= ALL_ON;
      retry_q <= '0;
      kick_q  <= 1'b1;
      lock_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      kick_q  <= (state_d == ST_ASSERT) || (state_d == ST_LOCKED);
      lock_q  <= (state_d == ST_LOCKED);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign seq.sys_rst     = mask_q;
  assign seq.wdt_kick    = kick_q;
  assign seq.fault_lock  = lock_q;
  assign seq.retry_count = retry_q;
  assign seq.busy        = busy_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Directed bench for the watchdog reset sequencer: a table of input/expected
// records walked in order, followed by a cycle-by-cycle release check.
module tb_wdt_reset_sequencer;

  logic clock;
  logic reset;

  wdt_reset_sequencer_if #(.NUM_STAGES(3), .RETRY_W(2)) bus ();

  wdt_reset_sequencer #(
    .HOLD_CYCLES  (16),
    .STAGE_GAP    (4),
    .NUM_STAGES   (3),
    .MAX_RETRIES  (3),
    .STABLE_CYCLES(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .seq  (bus)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       tmo;
    logic       clr;
    int         cycles;
    logic [2:0] exp_sys_rst;
    logic       exp_kick;
    logic       exp_lock;
    logic [1:0] exp_retry;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic add_vec(input string name, input logic rst, input logic tmo,
                         input logic clr, input int cycles, input logic [2:0] sr,
                         input logic kick, input logic lock, input logic [1:0] retry,
                         input logic busy);
    vec_t v;
    v.name = name; v.rst = rst; v.tmo = tmo; v.clr = clr; v.cycles = cycles;
    v.exp_sys_rst = sr; v.exp_kick = kick; v.exp_lock = lock;
    v.exp_retry = retry; v.exp_busy = busy;
    vecs.push_back(v);
  endtask

  // Hold the inputs for the given number of rising edges, settling 1 unit after each.
  task automatic apply_stimulus(input logic rst, input logic tmo, input logic clr,
                                input int cycles);
    reset           = rst;
    bus.wdt_timeout = tmo;
    bus.clear_fault = clr;
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [2:0] sr, input logic kick,
                              input logic lock, input logic [1:0] retry, input logic busy);
    checks++;
    if ({bus.sys_rst, bus.wdt_kick, bus.fault_lock, bus.retry_count, bus.busy} !==
        {sr, kick, lock, retry, busy}) begin
      errors++;
      $display("[TB] FAIL %s: got sys_rst=%b kick=%b lock=%b retry=%0d busy=%b, expected sys_rst=%b kick=%b lock=%b retry=%0d busy=%b",
               name, bus.sys_rst, bus.wdt_kick, bus.fault_lock, bus.retry_count, bus.busy,
               sr, kick, lock, retry, busy);
    end
  endtask

  // Expected stage mask c cycles after entering the hold: 16 held, then one bit every 4.
  function automatic logic [2:0] stage_mask(input int c);
    if (c < 16)      return 3'b111;
    else if (c < 20) return 3'b110;
    else if (c < 24) return 3'b100;
    else             return 3'b000;
  endfunction

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.wdt_timeout = 1'b0;
    bus.clear_fault = 1'b0;

    // Power-on release sequence.
    add_vec("por_c0",        1, 0, 0,  2, 3'b111, 1, 0, 0, 1);
    add_vec("por_c15",       0, 0, 0, 15, 3'b111, 1, 0, 0, 1);
    add_vec("por_c16",       0, 0, 0,  1, 3'b110, 0, 0, 0, 1);
    add_vec("por_c19",       0, 0, 0,  3, 3'b110, 0, 0, 0, 1);
    add_vec("por_c20",       0, 0, 0,  1, 3'b100, 0, 0, 0, 1);
    add_vec("por_c23",       0, 0, 0,  3, 3'b100, 0, 0, 0, 1);
    add_vec("por_c24",       0, 0, 0,  1, 3'b000, 0, 0, 0, 0);
    // Single timeout, then the stable window clears the count.
    add_vec("t2_tmo",        0, 1, 0,  1, 3'b111, 1, 0, 1, 1);
    add_vec("t2_c15",        0, 0, 0, 15, 3'b111, 1, 0, 1, 1);
    add_vec("t2_c16",        0, 0, 0,  1, 3'b110, 0, 0, 1, 1);
    add_vec("t2_c20",        0, 0, 0,  4, 3'b100, 0, 0, 1, 1);
    add_vec("t2_c24",        0, 0, 0,  4, 3'b000, 0, 0, 1, 0);
    add_vec("t2_idle63",     0, 0, 0, 63, 3'b000, 0, 0, 1, 0);
    add_vec("t2_idle64",     0, 0, 0,  1, 3'b000, 0, 0, 0, 0);
    add_vec("t2_idle70",     0, 0, 0,  6, 3'b000, 0, 0, 0, 0);
    // Repeated timeouts escalate to the lock; clear_fault recovers.
    add_vec("t3_tmo1",       0, 1, 0,  1, 3'b111, 1, 0, 1, 1);
    add_vec("t3_idle1",      0, 0, 0, 24, 3'b000, 0, 0, 1, 0);
    add_vec("t3_tmo2",       0, 1, 0,  1, 3'b111, 1, 0, 2, 1);
    add_vec("t3_idle2",      0, 0, 0, 24, 3'b000, 0, 0, 2, 0);
    add_vec("t3_tmo3",       0, 1, 0,  1, 3'b111, 1, 0, 3, 1);
    add_vec("t3_idle3",      0, 0, 0, 24, 3'b000, 0, 0, 3, 0);
    add_vec("t3_lock",       0, 1, 0,  1, 3'b111, 1, 1, 3, 1);
    add_vec("t3_lock_hold",  0, 1, 0, 10, 3'b111, 1, 1, 3, 1);
    add_vec("t3_clear",      0, 0, 1,  1, 3'b111, 1, 0, 0, 1);
    add_vec("t3_c24",        0, 0, 0, 24, 3'b000, 0, 0, 0, 0);
    // Timeout during release restarts the full hold; clear in ASSERT ignored.
    add_vec("t4_tmo",        0, 1, 0,  1, 3'b111, 1, 0, 1, 1);
    add_vec("t4_c16",        0, 0, 0, 16, 3'b110, 0, 0, 1, 1);
    add_vec("t4_c18",        0, 0, 0,  2, 3'b110, 0, 0, 1, 1);
    add_vec("t4_retmo",      0, 1, 0,  1, 3'b111, 1, 0, 2, 1);
    add_vec("t4_clr_assert", 0, 0, 1,  1, 3'b111, 1, 0, 2, 1);
    add_vec("t4_c15",        0, 0, 0, 14, 3'b111, 1, 0, 2, 1);
    add_vec("t4_c16b",       0, 0, 0,  1, 3'b110, 0, 0, 2, 1);
    add_vec("t4_c24",        0, 0, 0,  8, 3'b000, 0, 0, 2, 0);
    // Clear and timeout together, then clear during release.
    add_vec("t5_clr_tmo",    0, 1, 1,  1, 3'b111, 1, 0, 1, 1);
    add_vec("t5_c16",        0, 0, 0, 16, 3'b110, 0, 0, 1, 1);
    add_vec("t5_clr_rel",    0, 0, 1,  1, 3'b110, 0, 0, 0, 1);
    add_vec("t5_c24",        0, 0, 0,  7, 3'b000, 0, 0, 0, 0);
    // Reset in the middle of a release with two recoveries counted.
    add_vec("t6_tmo1",       0, 1, 0,  1, 3'b111, 1, 0, 1, 1);
    add_vec("t6_c17",        0, 0, 0, 17, 3'b110, 0, 0, 1, 1);
    add_vec("t6_tmo2",       0, 1, 0,  1, 3'b111, 1, 0, 2, 1);
    add_vec("t6_c17b",       0, 0, 0, 17, 3'b110, 0, 0, 2, 1);
    add_vec("t6_reset",      1, 0, 0,  1, 3'b111, 1, 0, 0, 1);
    add_vec("t6_c16",        0, 0, 0, 16, 3'b110, 0, 0, 0, 1);
    add_vec("t6_c24",        0, 0, 0,  8, 3'b000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].tmo, vecs[i].clr, vecs[i].cycles);
      check_output(vecs[i].name, vecs[i].exp_sys_rst, vecs[i].exp_kick,
                   vecs[i].exp_lock, vecs[i].exp_retry, vecs[i].exp_busy);
    end

    // Cycle-by-cycle staged release after a fresh timeout from IDLE.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    for (int c = 0; c < 30; c++) begin
      if (c > 0) apply_stimulus(1'b0, 1'b0, 1'b0, 1);
      check_output($sformatf("seq_c%0d", c), stage_mask(c), (c < 16), 1'b0, 2'd1, (c < 24));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdt_reset_sequencer.md
Name: wdt_reset_sequencer

Overview:
Downstream consumer of the watchdog timeout. It turns a watchdog expiry into a fixed-length system reset that is released in stages. It drives a kick back to the watchdog so the watchdog reloads during recovery. It counts consecutive recoveries and latches a fault lock when they exceed a limit.

Parameters:
HOLD_CYCLES, 16, cycles all stage resets are held asserted in ASSERT (>=1)
STAGE_GAP, 4, cycles between successive stage releases (>=1)
NUM_STAGES, 3, number of staged reset outputs (>=1)
MAX_RETRIES, 3, recoveries allowed before lock; the next timeout locks
STABLE_CYCLES, 64, continuous IDLE cycles that auto-clear retry_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wdt_timeout  in  1  watchdog expiry, level; stays high until the watchdog is kicked
clear_fault  in  1  software clear of retry count / lock, sampled per cycle
sys_rst  out  NUM_STAGES  active-high stage resets; bit 0 released first
wdt_kick  out  1  reload request to watchdog
fault_lock  out  1  escalation latched
retry_count  out  clog2(MAX_RETRIES+1)  recoveries since last clear
busy  out  1  high in any state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- On reset: state=ASSERT, timer=0, retry_count=0, sys_rst=all 1, wdt_kick=1, fault_lock=0, busy=1. Power-on therefore runs the full release sequence.
- States: IDLE, ASSERT, RELEASE, LOCKED (2-bit encoding).
- ASSERT:
  - sys_rst=all 1, wdt_kick=1.
  - Lasts exactly HOLD_CYCLES cycles.
  - On the last cycle, go to RELEASE; sys_rst[0] drops on that edge.
  - wdt_timeout is ignored in ASSERT because the kick clears it.
- RELEASE:
  - wdt_kick=0.
  - sys_rst[k] drops STAGE_GAP*k cycles after bit 0. Released bits stay low.
  - The edge that drops the last bit enters IDLE.
  - ASSERT entry to all-clear = HOLD_CYCLES + STAGE_GAP*(NUM_STAGES-1) cycles.
  - NUM_STAGES=1: ASSERT goes directly to IDLE.
- IDLE:
  - sys_rst=0, wdt_kick=0, busy=0.
  - The idle timer counts up and saturates at STABLE_CYCLES. When it reaches STABLE_CYCLES, retry_count=0.
- Timeout event (wdt_timeout=1 in IDLE or RELEASE):
  - If retry_count < MAX_RETRIES: retry_count+1, go to ASSERT, timer restarts, sys_rst=all 1 on the next edge.
  - Else: go to LOCKED; retry_count holds at MAX_RETRIES.
- LOCKED:
  - sys_rst=all 1, wdt_kick=1, fault_lock=1.
  - Exits only on clear_fault=1 (to ASSERT, retry_count=0, fault_lock=0) or on reset.
- clear_fault in IDLE or RELEASE zeroes retry_count.
  - Same cycle as a timeout: the clear applies first, then the increment, so the result is 1 and the state goes to ASSERT.
  - clear_fault in ASSERT is ignored.
- Any state leaving IDLE resets the idle timer.
- Reset mid-sequence: the next edge forces the reset values above.
- Timer width: clog2(max(HOLD_CYCLES, STAGE_GAP, STABLE_CYCLES)+1). A single timer is shared across states. No wrap: the timer is reloaded on every state change.

Decomposition:
- Package wdt_pkg holds:
  - the state enum;
  - default constants (HOLD_CYCLES, STAGE_GAP, NUM_STAGES, MAX_RETRIES, STABLE_CYCLES), shared with the watchdog's PERIOD.
- Single module; no sub-module. The stage mask is a shift register that shifts zeros in from bit 0.

Test Plan:
1. Power-on: reset=1 for 2 cycles, then 0 -> sys_rst=111 for 16 cycles, 110 at cycle 16, 100 at 20, 000 at 24; wdt_kick high cycles 0-15; busy falls at 24.
2. wdt_timeout pulsed in IDLE -> retry_count=1, same 24-cycle sequence; after 64 IDLE cycles retry_count=0.
3. Four timeouts, each within 64 IDLE cycles of the previous -> retry_count 1,2,3, then LOCKED: fault_lock=1, sys_rst=111, wdt_kick=1; clear_fault -> ASSERT, retry_count=0, fault_lock=0.
4. wdt_timeout while sys_rst=110 in RELEASE -> sys_rst=111 next edge, full 16-cycle hold restarts, retry_count increments.
5. retry_count=2 in IDLE, clear_fault and wdt_timeout in the same cycle -> retry_count=1, state ASSERT.
6. reset asserted mid-RELEASE with retry_count=2 -> next edge sys_rst=111, retry_count=0, fault_lock=0, wdt_kick=1.
